p_add_round: RTL and testbench

Pipelined add/normalize/round stage of the floating-point ALU datapath. It consumes the aligned, GRS-extended significands, the larger exponent and the resolved sign/effective-op from the alignment stage. It produces an IEEE-754 single-precision result, rounded to nearest-even, with overflow and inexact flags. Three registered stages sit behind a valid/ready handshake so that downstream back-pressure stalls the pipe without dropping or reordering operations.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/lzc27.sv | 20 ++
 rtl/p_add_round.sv | 147 ++++++++++++++
 tb/tb_p_add_round.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// fp_pkg -- single-precision widths, GRS bit positions and add/round pipeline payloads.
// Rev 1.0
package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int SIG_GRS_W = 28;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int QNAN_BIT  = 22;

    localparam int CARRY  = 27;
    localparam int HIDDEN = 26;
    localparam int G      = 2;
    localparam int R      = 1;
    localparam int S      = 0;

    // S1 -> S2: raw sum (holds significand A unchanged for specials)
    typedef struct packed {
        logic [SIG_GRS_W-1:0] sum;
        logic [EXP_W:0]       e;
        logic                 sign;
        logic                 special;
    } s1_t;

    // S2 -> S3: normalized {hidden, mantissa, G, R, S}
    typedef struct packed {
        logic [SIG_GRS_W-2:0] sig;
        logic [EXP_W:0]       e;
        logic                 denorm;
        logic                 sign;
        logic                 special;
    } s2_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/lzc27.sv
`default_nettype none
// lzc27 -- leading-zero count of a 27-bit vector; 27 when the vector is zero.
// Rev 1.0
module lzc27 (
    input  logic [26:0] vec,
    output logic [4:0]  count
);

    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (vec[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule : lzc27
`default_nettype wire

// File: rtl/p_add_round.sv
`default_nettype none
// p_add_round -- three-stage add / normalize / round-to-nearest-even, single precision.
// Rev 1.0
module p_add_round
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sign,
    input  logic                 op_implied,
    input  logic [EXP_W-1:0]     expA,
    input  logic [SIG_GRS_W-1:0] significand_grsA,
    input  logic [SIG_GRS_W-1:0] significand_grsB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          result,
    output logic                 overflow,
    output logic                 inexact
);

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    // A stage loads when empty or when its content moves on this cycle.
    assign ld3       = !v3 || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    // ---------------- S1: add / subtract ----------------
    always_comb begin
        s1_d         = '0;
        s1_d.sign    = sign;
        s1_d.special = (expA == EXP_MAX);
        s1_d.e       = (expA == '0) ? 9'd1 : {1'b0, expA};
        if (s1_d.special) begin
            s1_d.sum = significand_grsA;
        end else if (op_implied) begin
            s1_d.sum = significand_grsA - significand_grsB;
        end else begin
            s1_d.sum = significand_grsA + significand_grsB;
        end
    end

    // ---------------- S2: normalize ----------------
    logic [4:0]           lz;
    logic [EXP_W:0]       lim;
    logic [4:0]           sh;
    logic [SIG_GRS_W-2:0] shl;

    lzc27 u_lzc (
        .vec   (s1_q.sum[HIDDEN:0]),
        .count (lz)
    );

    // Left shift stops at exponent 1 so small results stay denormal.
    assign lim = s1_q.e - 9'd1;
    assign sh  = ({4'd0, lz} < lim) ? lz : lim[4:0];
    assign shl = s1_q.sum[HIDDEN:0] << sh;

    always_comb begin
        s2_d         = '0;
        s2_d.special = s1_q.special;
        s2_d.sign    = s1_q.sign;
        if (s1_q.special) begin
            s2_d.sig = s1_q.sum[HIDDEN:0];
        end else if (s1_q.sum[CARRY]) begin
            s2_d.sig = {s1_q.sum[CARRY:2], s1_q.sum[1] | s1_q.sum[0]};
            s2_d.e   = s1_q.e + 9'd1;
        end else begin
            s2_d.sig    = shl;
            s2_d.e      = s1_q.e - {4'd0, sh};
            s2_d.denorm = !shl[HIDDEN];
            if (s1_q.sum == '0) begin
                s2_d.sign = 1'b0;
            end
        end
    end

    // ---------------- S3: round to nearest even ----------------
    logic           up;
    logic [24:0]    inc;
    logic [EXP_W:0] ef;
    logic [31:0]    res_d;
    logic           ovf_d;
    logic           inx_d;

    always_comb begin
        up    = s2_q.sig[G] & (s2_q.sig[R] | s2_q.sig[S] | s2_q.sig[3]);
        inc   = {1'b0, s2_q.sig[HIDDEN:3]} + {24'd0, up};
        // Denormals gain exponent 1 only when rounding reaches the hidden bit.
        ef    = s2_q.denorm ? {8'd0, inc[MAN_W]} : s2_q.e + {8'd0, inc[MAN_W+1]};
        res_d = {s2_q.sign, ef[EXP_W-1:0], inc[MAN_W-1:0]};
        ovf_d = 1'b0;
        inx_d = |s2_q.sig[G:S];
        if (s2_q.special) begin
            res_d = {s2_q.sign, EXP_MAX, s2_q.sig[HIDDEN-1:3]};
            inx_d = 1'b0;
        end else if (ef >= 9'd255) begin
            res_d = {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            result   <= '0;
            overflow <= 1'b0;
            inexact  <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    s2_q <= s2_d;
                end
            end
            if (ld3) begin
                v3 <= v2;
                if (v2) begin
                    result   <= res_d;
                    overflow <= ovf_d;
                    inexact  <= inx_d;
                end
            end
        end
    end

endmodule : p_add_round
`default_nettype wire

// File: tb/tb_p_add_round.sv
`default_nettype none
// tb_p_add_round -- randomized and directed checks of p_add_round against an arithmetic model.
// Rev 1.0
module tb_p_add_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign = 1'b0;
    logic        op_implied = 1'b0;
    logic [7:0]  expA = '0;
    logic [27:0] significand_grsA = '0;
    logic [27:0] significand_grsB = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow;
    logic        inexact;

    always #5 clk = ~clk;

    p_add_round dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .sign             (sign),
        .op_implied       (op_implied),
        .expA             (expA),
        .significand_grsA (significand_grsA),
        .significand_grsB (significand_grsB),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .overflow         (overflow),
        .inexact          (inexact)
    );

    typedef struct packed {
        logic        sg;
        logic        op;
        logic [7:0]  ea;
        logic [27:0] a;
        logic [27:0] b;
        logic [33:0] expv;
    } op_t;

    op_t         pend[$];
    logic [33:0] exp_q[$];
    logic [33:0] mon_w;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          rand_bp = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected {overflow, inexact, result} from the arithmetic value of the sum.
    function automatic logic [33:0] model(input logic sg, input logic op, input logic [7:0] ea,
                                          input logic [27:0] a, input logic [27:0] b);
        longint      s;
        longint      keep;
        longint      rem;
        int          e;
        int          ef;
        logic [24:0] k;
        logic [7:0]  efb;
        if (ea == 8'hFF) return {2'b00, sg, 8'hFF, a[25:3]};
        s = op ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
        if (s == 0) return 34'd0;
        e = (ea == 8'd0) ? 1 : int'(ea);
        if (s >= (longint'(1) << 27)) begin
            s = (s >> 1) | (s & 1);
            e = e + 1;
        end
        while (s < (longint'(1) << 26) && e > 1) begin
            s = s << 1;
            e = e - 1;
        end
        keep = s >> 3;
        rem  = s & 7;
        if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep = keep + 1;
        if (keep == (longint'(1) << 24)) begin
            keep = keep >> 1;
            e = e + 1;
        end
        ef = (keep >= (longint'(1) << 23)) ? e : 0;
        if (ef >= 255) return {2'b11, sg, 8'hFF, 23'd0};
        k   = 25'(keep);
        efb = 8'(ef);
        return {1'b0, (rem != 0), sg, efb, k[22:0]};
    endfunction

    task automatic add_op(input logic sg, input logic op, input logic [7:0] ea,
                          input logic [27:0] a, input logic [27:0] b, input logic [33:0] want);
        op_t o;
        o.sg = sg; o.op = op; o.ea = ea; o.a = a; o.b = b; o.expv = want;
        pend.push_back(o);
    endtask

    task automatic add_rand();
        op_t         o;
        logic [22:0] man;
        logic [31:0] t;
        int          r;
        r = $urandom_range(0, 7);
        case (r)
            0:       o.ea = 8'd0;
            1:       o.ea = 8'd1;
            2:       o.ea = 8'd254;
            3:       o.ea = 8'hFF;
            default: o.ea = 8'($urandom_range(2, 253));
        endcase
        man  = 23'($urandom);
        o.a  = {1'b0, (o.ea != 8'd0), man, 3'b000};
        t    = $urandom % (32'(o.a) + 32'd1);
        o.b  = 28'(t) >> $urandom_range(0, 27);
        if ($urandom_range(0, 9) == 0) o.b = o.a;
        o.sg = 1'($urandom);
        o.op = 1'($urandom);
        o.expv = model(o.sg, o.op, o.ea, o.a, o.b);
        pend.push_back(o);
    endtask

    // Presents pending ops; an op counts as accepted when in_ready is seen high.
    task automatic drive(input int max_cycles, input bit until_empty);
        int cyc;
        cyc = 0;
        while (pend.size() != 0 && cyc < max_cycles) begin
            sign = pend[0].sg;
            op_implied = pend[0].op;
            expA = pend[0].ea;
            significand_grsA = pend[0].a;
            significand_grsB = pend[0].b;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(pend[0].expv);
                void'(pend.pop_front());
            end
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        in_valid = 1'b0;
        if (until_empty) check_eq("drive_timeout", 64'(pend.size()), 64'd0);
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_output", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_w = exp_q.pop_front();
                check_eq("result", {30'd0, overflow, inexact, result}, {30'd0, mon_w});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result",    64'(result),    64'd0);
        check_eq("rst_overflow",  64'(overflow),  64'd0);
        check_eq("rst_inexact",   64'(inexact),   64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        // 1.0 + 1.0 with a three-cycle latency probe
        add_op(1'b0, 1'b0, 8'd127, 28'h4000000, 28'h4000000, 34'h0_40000000);
        drive(10, 1'b1);
        @(negedge clk); check_eq("lat_c1", 64'(out_valid), 64'd0);
        @(negedge clk); check_eq("lat_c2", 64'(out_valid), 64'd0);
        @(negedge clk); check_eq("lat_c3", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        wait_drain();

        add_op(1'b0, 1'b1, 8'd127, 28'h4000000, 28'h4000000, 34'h0_00000000);
        add_op(1'b0, 1'b0, 8'd254, 28'h7FFFFF8, 28'h7FFFFF8, 34'h3_7F800000);
        add_op(1'b0, 1'b1, 8'd1,   28'h4000000, 28'h2000000, 34'h0_00400000);
        add_op(1'b0, 1'b0, 8'd127, 28'h4000000, 28'h0000004, 34'h1_3F800000);
        add_op(1'b0, 1'b0, 8'd127, 28'h4000008, 28'h0000004, 34'h1_3F800002);
        add_op(1'b1, 1'b0, 8'hFF,  28'h4000008, 28'h1234567, 34'h0_FF800001);
        add_op(1'b1, 1'b1, 8'd127, 28'h4000000, 28'h4000000, 34'h0_00000000);
        drive(50, 1'b1);
        wait_drain();

        // Back-pressure: five ops against a stalled output
        out_ready = 1'b0;
        repeat (5) add_rand();
        drive(6, 1'b0);
        check_eq("bp_accepted", 64'(5 - pend.size()), 64'd3);
        @(negedge clk);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(50, 1'b1);
        wait_drain();

        // Randomized traffic with random downstream stalls
        rand_bp = 1'b1;
        repeat (300) add_rand();
        drive(3000, 1'b1);
        rand_bp = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-stream discards in-flight ops
        out_ready = 1'b0;
        repeat (2) add_rand();
        drive(10, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("rst_mid_quiet", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        add_op(1'b0, 1'b0, 8'd127, 28'h4000000, 28'h4000000, 34'h0_40000000);
        drive(10, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_p_add_round
`default_nettype wire
